// File: rtl/minimac2_rxsched.sv
// Receive-slot scheduler for the minimac2 dual RX buffer: arms slots, queues completed frames in order.
// Optional runt filtering is enabled by defining MINIMAC2_RXSCHED_RUNT_EN.
module minimac2_rxsched #(
  parameter int MIN_LEN = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic [1:0]  rx_ready,
  input  logic [1:0]  rx_done,
  input  logic [10:0] rx_count_0,
  input  logic [10:0] rx_count_1,
  output logic        frm_valid,
  output logic        frm_slot,
  output logic [10:0] frm_count,
  input  logic        frm_ready,
  output logic        irq_rx,
  output logic        err_unarmed,
  output logic [15:0] runt_count
);

`ifdef MINIMAC2_RXSCHED_RUNT_EN
  localparam bit RUNT_EN = 1'b1;
`else
  localparam bit RUNT_EN = 1'b0;
`endif
  localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FULL  = 2'd2
  } slot_state_e;

  slot_state_e state_q [2];
  slot_state_e state_d [2];
  logic [10:0] cnt_q [2];
  logic [10:0] cnt_d [2];
  logic [10:0] cnt_in [2];
  logic [1:0]  push, runt, bad_done, ready_d;
  logic [1:0]  fifo_q, fifo_d;
  logic [1:0]  occ_q, occ_d;
  logic        frm_valid_q, frm_valid_d;
  logic        frm_slot_q, frm_slot_d;
  logic [10:0] frm_count_q, frm_count_d;
  logic [1:0]  rx_ready_q;
  logic        err_q;
  logic [15:0] runt_q, runt_d;
  logic [16:0] runt_sum;
  logic        xfer;

  assign cnt_in[0] = rx_count_0;
  assign cnt_in[1] = rx_count_1;
  assign xfer      = frm_valid_q & frm_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      slot_state_e st_d;
      logic [10:0] c_d;
      logic        push_g, runt_g, bad_g;

      always_comb begin
        st_d   = state_q[gi];
        c_d    = cnt_q[gi];
        push_g = 1'b0;
        runt_g = 1'b0;
        bad_g  = 1'b0;
        case (state_q[gi])
          S_IDLE: begin
            bad_g = rx_done[gi];
            if (enable) st_d = S_ARMED;
          end
          S_ARMED: begin
            if (rx_done[gi]) begin
              if (RUNT_EN && (cnt_in[gi] < MIN_LEN_W)) begin
                runt_g = 1'b1;
              end else begin
                st_d   = S_FULL;
                c_d    = cnt_in[gi];
                push_g = 1'b1;
              end
            end
          end
          S_FULL: begin
            // A done pulse here (even alongside this slot's transfer) is unarmed.
            bad_g = rx_done[gi];
            if (xfer && (frm_slot_q == 1'(gi))) st_d = enable ? S_ARMED : S_IDLE;
          end
          default: st_d = S_IDLE;
        endcase
      end

      assign state_d[gi]  = st_d;
      assign cnt_d[gi]    = c_d;
      assign push[gi]     = push_g;
      assign runt[gi]     = runt_g;
      assign bad_done[gi] = bad_g;
      assign ready_d[gi]  = (st_d == S_ARMED);
    end
  endgenerate

  // Pop before push; slot 0 lands ahead of slot 1 on simultaneous completions.
  always_comb begin
    fifo_d = fifo_q;
    occ_d  = occ_q;
    if (xfer) begin
      fifo_d[0] = fifo_q[1];
      occ_d     = occ_q - 2'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_d[occ_d[0]] = 1'(i);
        occ_d            = occ_d + 2'd1;
      end
    end
  end

  always_comb begin
    frm_valid_d = (occ_d != 2'd0);
    frm_slot_d  = frm_slot_q;
    frm_count_d = frm_count_q;
    if (occ_d != 2'd0) begin
      frm_slot_d  = fifo_d[0];
      frm_count_d = cnt_d[fifo_d[0]];
    end
    runt_sum = {1'b0, runt_q} + 17'(runt[0]) + 17'(runt[1]);
    runt_d   = runt_sum[16] ? 16'hFFFF : runt_sum[15:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 11'd0;
      end
      fifo_q      <= 2'b00;
      occ_q       <= 2'd0;
      frm_valid_q <= 1'b0;
      frm_slot_q  <= 1'b0;
      frm_count_q <= 11'd0;
      rx_ready_q  <= 2'b00;
      err_q       <= 1'b0;
      runt_q      <= 16'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      fifo_q      <= fifo_d;
      occ_q       <= occ_d;
      frm_valid_q <= frm_valid_d;
      frm_slot_q  <= frm_slot_d;
      frm_count_q <= frm_count_d;
      rx_ready_q  <= ready_d;
      err_q       <= err_q | (|bad_done);
      runt_q      <= runt_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign frm_valid   = frm_valid_q;
  assign frm_slot    = frm_slot_q;
  assign frm_count   = frm_count_q;
  assign irq_rx      = frm_valid_q;
  assign err_unarmed = err_q;
  assign runt_count  = runt_q;

endmodule

// File: tb/tb_minimac2_rxsched.sv
// Randomised + directed bench for minimac2_rxsched against a queue-based slot/frame model.
module tb_minimac2_rxsched;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [1:0]  rx_ready;
  logic [1:0]  rx_done;
  logic [10:0] rx_count_0, rx_count_1;
  logic        frm_valid, frm_slot;
  logic [10:0] frm_count;
  logic        frm_ready;
  logic        irq_rx, err_unarmed;
  logic [15:0] runt_count;

`ifdef MINIMAC2_RXSCHED_RUNT_EN
  localparam bit M_RUNT = 1'b1;
`else
  localparam bit M_RUNT = 1'b0;
`endif
  localparam int M_MIN = 64;

  minimac2_rxsched #(.MIN_LEN(M_MIN)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .rx_ready(rx_ready), .rx_done(rx_done),
    .rx_count_0(rx_count_0), .rx_count_1(rx_count_1),
    .frm_valid(frm_valid), .frm_slot(frm_slot), .frm_count(frm_count),
    .frm_ready(frm_ready), .irq_rx(irq_rx), .err_unarmed(err_unarmed),
    .runt_count(runt_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: slot status 0=idle 1=armed 2=full, frames waiting in arrival order.
  int  m_st [2];
  int  m_cnt [2];
  bit  m_q [$];
  bit  m_err;
  int  m_runt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st[0] = 0; m_st[1] = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_q.delete();
    m_err = 1'b0;
    m_runt = 0;
  endtask

  task automatic model_step(input bit en, input bit [1:0] done, input int c0, input int c1, input bit rdy);
    bit tx, tslot;
    bit pushes [2];
    int nst [2];
    int cin [2];
    cin[0] = c0; cin[1] = c1;
    tx = (m_q.size() != 0) && rdy;
    tslot = tx ? m_q[0] : 1'b0;
    for (int i = 0; i < 2; i++) begin
      pushes[i] = 1'b0;
      nst[i] = m_st[i];
      if (m_st[i] == 0 && en) nst[i] = 1;
      if (m_st[i] == 2 && tx && tslot == 1'(i)) nst[i] = en ? 1 : 0;
      if (done[i]) begin
        if (m_st[i] != 1) m_err = 1'b1;
        else if (M_RUNT && cin[i] < M_MIN) m_runt = (m_runt >= 65535) ? 65535 : m_runt + 1;
        else begin
          nst[i] = 2;
          m_cnt[i] = cin[i];
          pushes[i] = 1'b1;
        end
      end
    end
    m_st[0] = nst[0]; m_st[1] = nst[1];
    if (tx) void'(m_q.pop_front());
    for (int i = 0; i < 2; i++) if (pushes[i]) m_q.push_back(1'(i));
  endtask

  task automatic check_all();
    chk("rx_ready", 32'(rx_ready), 32'({m_st[1] == 1, m_st[0] == 1}));
    chk("frm_valid", 32'(frm_valid), 32'(m_q.size() != 0));
    chk("irq_rx", 32'(irq_rx), 32'(m_q.size() != 0));
    chk("err_unarmed", 32'(err_unarmed), 32'(m_err));
    chk("runt_count", 32'(runt_count), 32'(m_runt));
    if (m_q.size() != 0) begin
      chk("frm_slot", 32'(frm_slot), 32'(m_q[0]));
      chk("frm_count", 32'(frm_count), 32'(m_cnt[m_q[0]]));
    end
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit en, input bit [1:0] done, input int c0, input int c1, input bit rdy);
    enable = en; rx_done = done;
    rx_count_0 = 11'(c0); rx_count_1 = 11'(c1);
    frm_ready = rdy;
    @(posedge sys_clk);
    model_step(en, done, c0, c1, rdy);
    #1;
    check_all();
    @(negedge sys_clk);
    rx_done = 2'b00;
  endtask

  initial begin
    bit en, rdy;
    bit [1:0] d;
    int c0, c1;
    sys_rst_n = 1'b0; enable = 1'b1; rx_done = 2'b00;
    rx_count_0 = 11'd0; rx_count_1 = 11'd0; frm_ready = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge sys_clk);
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_frm_valid", 32'(frm_valid), 32'd0);
      chk("rst_frm_slot", 32'(frm_slot), 32'd0);
      chk("rst_frm_count", 32'(frm_count), 32'd0);
      chk("rst_irq", 32'(irq_rx), 32'd0);
      chk("rst_err", 32'(err_unarmed), 32'd0);
      chk("rst_runt", 32'(runt_count), 32'd0);
    end
    sys_rst_n = 1'b1;

    // Directed walk through the main scenarios.
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b01, 100, 0, 0);
    cycle(1, 2'b00, 0, 0, 1);
    cycle(1, 2'b11, 200, 300, 0);
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 1);
    cycle(1, 2'b10, 0, 999, 0);
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 1);
    cycle(1, 2'b01, 500, 0, 0);
    cycle(0, 2'b00, 0, 0, 1);
    cycle(0, 2'b00, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b01, 63, 0, 0);
    cycle(1, 2'b00, 0, 0, 1);
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b01, 64, 0, 0);
    cycle(1, 2'b00, 0, 0, 1);
    cycle(1, 2'b01, 0, 0, 1);

    // Random traffic, mostly legal completions with occasional stray pulses.
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      for (int i = 0; i < 2; i++)
        d[i] = (m_st[i] == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      c0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 2047);
      c1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 2047);
      cycle(en, d, c0, c1, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
